uart_rx: RTL and testbench

- Oversampling UART receiver: converts the asynchronous serial line RX_IN into 8-bit parallel words.
- Frame format: start bit (0), 8 data bits LSB first, optional even/odd parity bit, 1 stop bit (1).
- Runs on a fast clock that is Prescale times the bit rate.
- Sits in the UART block between the pad/synchroniser and the system data path; reports parity and stop-bit errors.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3 vote of the three mid-bit samples.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  Par_En,
    input  logic                  Par_Typ,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  PAR_Err,
    output logic                  STP_Err
);
    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  dv_q, dv_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;

    logic [PRESCALE_W-1:0] half, last_edge;
    logic                  bit_end, bit_val, par_exp;

    assign half      = Prescale >> 1;
    assign last_edge = Prescale - PRESCALE_W'(1);
    // >= rather than == so a mid-frame Prescale shrink still ends the bit
    assign bit_end   = (edge_cnt_q >= last_edge);
    assign par_exp   = par_typ_q ? ~^shift_q : ^shift_q;

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] smp_q, smp_d;

    always_comb begin
        smp_d = smp_q;
        if (state_q != IDLE) begin
            if (edge_cnt_q == half - PRESCALE_W'(1)) smp_d[0] = RX_IN;
            if (edge_cnt_q == half)                  smp_d[1] = RX_IN;
            if (edge_cnt_q == half + PRESCALE_W'(1)) smp_d[2] = RX_IN;
        end
    end

    assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
`else
    logic smp_q, smp_d;

    always_comb begin
        smp_d = smp_q;
        if (state_q != IDLE && edge_cnt_q == half) smp_d = RX_IN;
    end

    assign bit_val = smp_q;
`endif

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        p_data_d   = p_data_q;
        dv_d       = 1'b0;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                // The detecting clock is edge 0 of the start bit, so back-to-back frames stay aligned
                if (!RX_IN) begin
                    state_d    = START;
                    edge_cnt_d = PRESCALE_W'(1);
                    par_err_d  = 1'b0;
                    stp_err_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    if (bit_val) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        par_en_d  = Par_En;
                        par_typ_d = Par_Typ;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
                    else                       bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    if (bit_val != par_exp) par_err_d = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_err_d = ~bit_val;
                    if (!par_err_q && bit_val) begin
                        p_data_d = shift_q;
                        dv_d     = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            p_data_q   <= p_data_d;
            dv_q       <= dv_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        smp_q   <= smp_d;
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = dv_q;
    assign PAR_Err    = par_err_q;
    assign STP_Err    = stp_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random serial frames checked against a frame-level model.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid, PAR_Err, STP_Err;

    int         total = 0;
    int         bad = 0;
    int         dv_cnt = 0;
    int         dv_double = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] model_pdata = 8'h00;

    uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX_IN     (RX_IN),
        .Prescale  (prescale),
        .Par_En    (par_en),
        .Par_Typ   (par_typ),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_Err   (PAR_Err),
        .STP_Err   (STP_Err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (Data_Valid) dv_cnt++;
        if (Data_Valid && dv_prev) dv_double++;
        dv_prev = Data_Valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (prescale) @(negedge clk);
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic good_parity(input logic [7:0] d, input logic odd);
        return logic'(($countones(d) + int'(odd)) % 2);
    endfunction

    // Model: the frame is accepted only if the ones-count (data + parity bit) matches the parity type
    // and the stop bit is 1; otherwise P_DATA keeps its old value.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stopb, input string tag);
        logic exp_pe, exp_se, exp_dv;
        exp_pe = par_en && ((($countones(d) + int'(pbit)) % 2) != int'(par_typ));
        exp_se = !stopb;
        exp_dv = !exp_pe && !exp_se;
        send_bit(1'b0);
        chk({tag, "_flags_clr_at_start"}, {30'd0, PAR_Err, STP_Err}, 32'd0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) begin
            send_bit(pbit);
            chk({tag, "_par_err_at_par_end"}, {31'd0, PAR_Err}, {31'd0, exp_pe});
        end
        send_bit(stopb);
        if (exp_dv) model_pdata = d;
        chk({tag, "_dv"}, {31'd0, Data_Valid}, {31'd0, exp_dv});
        chk({tag, "_pdata"}, {24'd0, P_DATA}, {24'd0, model_pdata});
        chk({tag, "_par_err"}, {31'd0, PAR_Err}, {31'd0, exp_pe});
        chk({tag, "_stp_err"}, {31'd0, STP_Err}, {31'd0, exp_se});
    endtask

    initial begin
        int         base;
        int         n_dv;
        logic [7:0] d;
        logic       pb, sb;

        repeat (3) @(negedge clk);
        chk("reset_pdata", {24'd0, P_DATA}, 32'd0);
        chk("reset_dv", {31'd0, Data_Valid}, 32'd0);
        chk("reset_par", {31'd0, PAR_Err}, 32'd0);
        chk("reset_stp", {31'd0, STP_Err}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Odd parity 0xA5
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b1;
        base = dv_cnt;
        send_frame(8'hA5, 1'b1, 1'b1, "a5");
        idle(2);
        chk("a5_one_pulse", dv_cnt - base, 32'd1);

        // 25 back-to-back even-parity frames
        par_typ = 1'b0;
        base = dv_cnt;
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            send_frame(d, good_parity(d, 1'b0), 1'b1, "b2b");
        end
        idle(2);
        chk("b2b_pulses", dv_cnt - base, 32'd25);

        // No parity, larger prescales
        par_en = 1'b0; prescale = 6'd16;
        send_frame(8'h3C, 1'b0, 1'b1, "p16_3c");
        idle(4);
        prescale = 6'd32;
        send_frame(8'hFF, 1'b0, 1'b1, "p32_ff");
        idle(4);

        // Parity error, then stop error (its start also checks PAR_Err clears)
        prescale = 6'd8; par_en = 1'b1; par_typ = 1'b0;
        base = dv_cnt;
        send_frame(8'h01, 1'b0, 1'b1, "par_err");
        idle(3);
        par_en = 1'b0;
        send_frame(8'h55, 1'b0, 1'b0, "stp_err");
        idle(5);
        chk("stp_err_held", {31'd0, STP_Err}, 32'd1);
        chk("err_no_pulse", dv_cnt - base, 32'd0);

        // Start glitch shorter than half a bit
        RX_IN = 1'b0;
        repeat (prescale / 2 - 2) @(negedge clk);
        idle(2 * prescale);
        chk("glitch_flags", {30'd0, PAR_Err, STP_Err}, 32'd0);
        chk("glitch_no_pulse", dv_cnt - base, 32'd0);
        chk("glitch_pdata", {24'd0, P_DATA}, {24'd0, model_pdata});
        send_frame(8'h96, 1'b0, 1'b1, "after_glitch");
        idle(2);

        // Random frames with random prescale, parity mode and injected errors
        base = dv_cnt;
        n_dv = 0;
        for (int i = 0; i < 12; i++) begin
            prescale = 6'(2 * $urandom_range(3, 16));
            par_en   = 1'($urandom);
            par_typ  = 1'($urandom);
            d        = 8'($urandom);
            pb       = good_parity(d, par_typ) ^ ($urandom_range(0, 3) == 0);
            sb       = ($urandom_range(0, 4) != 0);
            if (sb && (!par_en || pb == good_parity(d, par_typ))) n_dv++;
            send_frame(d, pb, sb, "rand");
            idle(int'($urandom_range(1, 5)));
        end
        idle(2);
        chk("rand_pulses", dv_cnt - base, n_dv);

        // Reset in the middle of the data bits
        prescale = 6'd8; par_en = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, "pre_rst");
        idle(3);
        base = dv_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_pdata = 8'h00;
        chk("midrst_pdata", {24'd0, P_DATA}, 32'd0);
        chk("midrst_dv", {31'd0, Data_Valid}, 32'd0);
        chk("midrst_flags", {30'd0, PAR_Err, STP_Err}, 32'd0);
        RX_IN = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(12);
        chk("midrst_no_pulse", dv_cnt - base, 32'd0);
        send_frame(8'hC3, 1'b0, 1'b1, "post_rst");
        idle(3);

        chk("dv_never_double", dv_double, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
